edge_interval_meter: RTL and testbench
======================================

Name: edge_interval_meter

Overview:
Sits directly downstream of double_edge_detect. It consumes that block's single-cycle edge pulses and measures the clk-cycle interval between consecutive pulses. Each valid interval is queued in a small FIFO and presented on a valid/ready output. Sticky flags report dropped results (FIFO overflow) and lost signal (timeout).

Parameters:
CNT_W, 16, width of interval counter and of result data
ADDR_W, 2, FIFO address width; depth = 2**ADDR_W
MIN_INTERVAL, 2, intervals shorter than this are rejected as glitches (range 1..2**CNT_W-2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_pulse  in  1  single-cycle edge pulse, driven by double_edge_detect out
clear  in  1  synchronous flush: empties FIFO, clears flags, returns to IDLE
interval_data  out  CNT_W  FIFO head: measured interval in clk cycles
interval_valid  out  1  FIFO non-empty
interval_ready  in  1  consumer accepts head when valid&&ready
level  out  ADDR_W+1  FIFO occupancy, 0..2**ADDR_W
busy  out  1  1 while in RUN state
overflow  out  1  sticky: a measurement was dropped because the FIFO was full
timeout  out  1  sticky: counter saturated with no pulse

Behaviour:
- Reset (reset==0, async): state=IDLE, cnt=0, FIFO empty and storage zeroed, level=0. All outputs are 0: interval_valid, interval_data, busy, overflow, timeout.
- FSM, two states:
  - IDLE: on in_pulse -> RUN, cnt<=1; no push.
  - RUN, no pulse this cycle: cnt<=cnt+1. If cnt==2**CNT_W-1 before the increment -> timeout<=1, state<=IDLE, cnt<=0, no push.
  - RUN, in_pulse: measured value k = current cnt, i.e. the number of rising edges from one pulse to the next. If k>=MIN_INTERVAL, push k. Otherwise reject it without a push. In both cases cnt<=1 and the FSM stays in RUN; a rejected pulse becomes the new start point.
- busy = (state==RUN), registered.
- Latency: a pushed value is visible at the FIFO head with interval_valid=1 one cycle after the clock edge that sampled the ending pulse, provided the FIFO was empty.
- FIFO:
  - First-word-fall-through; interval_data = head entry, 0 when empty.
  - Pop on interval_valid&&interval_ready; ready while empty is ignored.
  - Push into a full FIFO with no pop in the same cycle: value dropped, overflow<=1, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, level unchanged.
  - Push and pop in the same cycle when level==1: the new value becomes head next cycle, level stays 1.
  - Pointers wrap modulo 2**ADDR_W. level tracks occupancy exactly, registered.
- clear (sync, highest priority): FIFO emptied, level=0, overflow=0, timeout=0, state=IDLE, cnt=0. in_pulse and pop in the same cycle are ignored.
- Sticky flags clear only on reset or clear.
- Reset asserted mid-measurement or with FIFO data: everything aborts immediately, no partial results. After release, the first in_pulse is treated as a start edge only.
- Arithmetic is unsigned. The counter never wraps; saturation leads to timeout.

Test Plan:
1. Defaults, ready=1; pulses every 5 cycles, 6 pulses -> 5 results, each data=5; valid one cycle after each pulse from the 2nd onward; level never exceeds 1; busy=1 from the cycle after the 1st pulse.
2. Square-wave in, high 2 / low 6 cycles, through double_edge_detect into in_pulse, ready=1 -> data stream alternates 2,6,2,6...; no overflow, no timeout.
3. ready=0; 6 pulses spaced 10 -> level reaches 4 holding 10,10,10,10; 5th interval dropped, overflow=1. Then ready=1 -> four pops of 10, level 4->0, valid=0, overflow stays 1.
4. MIN_INTERVAL=2; pulses at t, t+1, t+8 -> interval 1 rejected, no push; single result data=7; level=1.
5. CNT_W=4; one pulse, then 20 idle cycles -> timeout=1 and busy=0 after 15 counted cycles, no push. Then pulses spaced 3: first restarts measurement, the next yields data=3; timeout remains 1 until clear.
6. FIFO full (level=4), overflow=1, measurement in RUN; pulse clear coincident with in_pulse -> next cycle level=0, valid=0, overflow=0, busy=0. Repeat with reset=0 instead -> outputs 0 immediately, before any clk edge.

Source files
------------

// File: rtl/edge_interval_meter.sv
// edge_interval_meter: measures the clk-cycle spacing between consecutive
// single-cycle edge pulses and queues each accepted interval in a small
// first-word-fall-through FIFO with sticky overflow/timeout flags.
module edge_interval_meter #(
  parameter int CNT_W        = 16,
  parameter int ADDR_W       = 2,
  parameter int MIN_INTERVAL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_pulse,
  input  logic              clear,
  output logic [CNT_W-1:0]  interval_data,
  output logic              interval_valid,
  input  logic              interval_ready,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              overflow,
  output logic              timeout
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_K    = CNT_W'(MIN_INTERVAL);
  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    mem_q [DEPTH];
  logic [CNT_W-1:0]    mem_d [DEPTH];
  logic [ADDR_W-1:0]   wr_q, wr_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                overflow_q, overflow_d;
  logic                timeout_q, timeout_d;

  logic                push_req;
  logic                timeout_set;
  logic                pop;
  logic                full;
  logic                do_push;
  logic                drop;

  // Measurement FSM: counts cycles between pulses, requests a push on each
  // qualifying interval, and gives up (timeout) when the counter saturates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    push_req    = 1'b0;
    timeout_set = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_pulse) begin
            state_d = RUN;
            cnt_d   = CNT_ONE;
          end
        end
        RUN: begin
          if (in_pulse) begin
            // A rejected short interval still restarts the measurement here.
            push_req = (cnt_q >= MIN_K);
            cnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_set = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: push/pop arbitration, occupancy and sticky flags.
  always_comb begin
    pop        = interval_valid && interval_ready && !clear;
    full       = (level_q == FULL_LVL);
    do_push    = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (clear) begin
      wr_d       = '0;
      rd_d       = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = cnt_q;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      level_d    = level_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(pop);
      overflow_d = overflow_q | drop;
      timeout_d  = timeout_q | timeout_set;
    end
  end

  // State, counter, FIFO storage and flag registers; reset aborts everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign interval_valid = (level_q != '0);
  assign interval_data  = interval_valid ? mem_q[rd_q] : '0;
  assign level          = level_q;
  assign busy           = (state_q == RUN);
  assign overflow       = overflow_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_edge_interval_meter.sv
// Directed bench for edge_interval_meter: default instance for FIFO and
// interval behaviour, a CNT_W=4 instance for counter saturation.
module tb_edge_interval_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_pulse = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] data;
  logic        valid;
  logic [2:0]  level;
  logic        busy, overflow, timeout;

  logic        p4 = 1'b0;
  logic [3:0]  data4;
  logic        valid4;
  logic [2:0]  level4;
  logic        busy4, overflow4, timeout4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_interval_meter dut (
    .clk(clk), .reset(reset), .in_pulse(in_pulse), .clear(clear),
    .interval_data(data), .interval_valid(valid), .interval_ready(ready),
    .level(level), .busy(busy), .overflow(overflow), .timeout(timeout)
  );

  edge_interval_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_pulse(p4), .clear(clear),
    .interval_data(data4), .interval_valid(valid4), .interval_ready(1'b1),
    .level(level4), .busy(busy4), .overflow(overflow4), .timeout(timeout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    in_pulse = 1'b1;
    tick();
    in_pulse = 1'b0;
  endtask

  task automatic pulse4();
    p4 = 1'b1;
    tick();
    p4 = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state, checked before any clock edge
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout, 0);
    step(2);
    reset = 1'b1;
    step(1);

    // 1: pulses every 5 cycles, ready=1
    pulse();
    chk("t1_busy", busy, 1);
    chk("t1_first_valid", valid, 0);
    step(4);
    for (int i = 0; i < 5; i++) begin
      pulse();
      chk("t1_valid", valid, 1);
      chk("t1_data", data, 5);
      chk("t1_level", level, 1);
      tick();
      chk("t1_popped", level, 0);
      step(3);
    end

    // 2: square wave high 2 / low 6 -> edges spaced 2,6,2,6
    do_clear();
    chk("t2_clr_busy", busy, 0);
    pulse();
    for (int i = 0; i < 4; i++) begin
      automatic int g = (i % 2 == 0) ? 2 : 6;
      step(g - 1);
      pulse();
      chk("t2_valid", valid, 1);
      chk("t2_data", data, g);
    end
    chk("t2_ovf", overflow, 0);
    chk("t2_tmo", timeout, 0);

    // 3: ready=0, fill FIFO, drop the 5th, then drain
    do_clear();
    ready = 1'b0;
    pulse();
    for (int i = 1; i <= 5; i++) begin
      step(9);
      pulse();
      chk("t3_level", level, (i < 4) ? i : 4);
      chk("t3_ovf", overflow, (i < 5) ? 0 : 1);
    end
    ready = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      chk("t3_head", data, 10);
      tick();
      chk("t3_drain", level, i - 1);
    end
    chk("t3_empty_valid", valid, 0);
    chk("t3_empty_data", data, 0);
    chk("t3_ovf_sticky", overflow, 1);

    // 4: interval 1 rejected, pulse becomes the new start
    do_clear();
    pulse();
    pulse();
    chk("t4_reject_level", level, 0);
    chk("t4_reject_valid", valid, 0);
    step(6);
    pulse();
    chk("t4_data", data, 7);
    chk("t4_level", level, 1);

    // 5: CNT_W=4 saturation -> timeout
    pulse4();
    step(14);
    chk("t5_pre_tmo", timeout4, 0);
    chk("t5_pre_busy", busy4, 1);
    tick();
    chk("t5_tmo", timeout4, 1);
    chk("t5_busy", busy4, 0);
    chk("t5_level", level4, 0);
    step(5);
    pulse4();
    chk("t5_restart_level", level4, 0);
    step(2);
    pulse4();
    chk("t5_data", data4, 3);
    chk("t5_valid", valid4, 1);
    chk("t5_tmo_sticky", timeout4, 1);
    do_clear();
    chk("t5_tmo_clr", timeout4, 0);

    // 6: clear coincident with in_pulse while full and running
    ready = 1'b0;
    pulse();
    for (int i = 0; i < 5; i++) begin
      step(9);
      pulse();
    end
    chk("t6_full", level, 4);
    chk("t6_ovf", overflow, 1);
    step(3);
    clear = 1'b1;
    in_pulse = 1'b1;
    tick();
    clear = 1'b0;
    in_pulse = 1'b0;
    chk("t6_clr_level", level, 0);
    chk("t6_clr_valid", valid, 0);
    chk("t6_clr_ovf", overflow, 0);
    chk("t6_clr_busy", busy, 0);

    // 6b: same situation, asynchronous reset instead
    pulse();
    for (int i = 0; i < 5; i++) begin
      step(9);
      pulse();
    end
    chk("t6b_full", level, 4);
    step(3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6b_level", level, 0);
    chk("t6b_valid", valid, 0);
    chk("t6b_data", data, 0);
    chk("t6b_busy", busy, 0);
    chk("t6b_ovf", overflow, 0);
    tick();
    reset = 1'b1;
    ready = 1'b1;
    step(1);
    pulse();
    chk("t6b_start_only", level, 0);
    chk("t6b_start_busy", busy, 1);
    step(2);
    pulse();
    chk("t6b_data_after", data, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
